// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer: Moore FSM with tick-based phase timers and
// pedestrian WALK insertion. Define NIGHT_FLASH_EN to add the night flashing-yellow mode.
module traffic_phase_ctrl #(
   parameter int TW        = 8,
   parameter int GREEN_T   = 10,
   parameter int MIN_GREEN = 4,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          ped_req,
`ifdef NIGHT_FLASH_EN
   input  logic          night,
`endif
   output logic [2:0]    ns_light,
   output logic [2:0]    ew_light,
   output logic          ped_walk,
   output logic          ped_pending,
   output logic [2:0]    phase,
   output logic [TW-1:0] remaining
);

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR_A  = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      AR_B  = 3'd5,
      WALK  = 3'd6,
      FLASH = 3'd7
   } phase_t;

   localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_T - 1);
   localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
   localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_T - 1);

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   phase_t          phase_reg, phase_next, exit_target;
   logic [TW-1:0]   cnt_reg, cnt_next;
   logic            pend_reg, pend_next;
   logic            next_dir_reg, next_dir_next;
   logic            phase_exit;
   logic            green_done;
   logic            enter_walk;
`ifdef NIGHT_FLASH_EN
   logic            flash_reg, flash_next;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_reg    <= NS_G;
         cnt_reg      <= '0;
         pend_reg     <= 1'b0;
         next_dir_reg <= DIR_EW;
`ifdef NIGHT_FLASH_EN
         flash_reg    <= 1'b1;
`endif
      end else begin
         phase_reg    <= phase_next;
         cnt_reg      <= cnt_next;
         pend_reg     <= pend_next;
         next_dir_reg <= next_dir_next;
`ifdef NIGHT_FLASH_EN
         flash_reg    <= flash_next;
`endif
      end
   end

   // Early cut relies on the registered request, so a same-cycle request never cuts.
   assign green_done = (cnt_reg == GREEN_LAST) || (pend_reg && (cnt_reg >= MIN_LAST));

   always_comb begin
      phase_exit  = 1'b0;
      exit_target = NS_G;
      case (phase_reg)
         NS_G: begin
            phase_exit  = tick && green_done;
            exit_target = NS_Y;
         end
         NS_Y: begin
            phase_exit  = tick && (cnt_reg == YELLOW_LAST);
            exit_target = AR_A;
         end
         AR_A: begin
            phase_exit  = tick && (cnt_reg == ALLRED_LAST);
            exit_target = pend_reg ? WALK : EW_G;
`ifdef NIGHT_FLASH_EN
            if (night) exit_target = FLASH;
`endif
         end
         EW_G: begin
            phase_exit  = tick && green_done;
            exit_target = EW_Y;
         end
         EW_Y: begin
            phase_exit  = tick && (cnt_reg == YELLOW_LAST);
            exit_target = AR_B;
         end
         AR_B: begin
            phase_exit  = tick && (cnt_reg == ALLRED_LAST);
            exit_target = pend_reg ? WALK : NS_G;
`ifdef NIGHT_FLASH_EN
            if (night) exit_target = FLASH;
`endif
         end
         WALK: begin
            phase_exit  = tick && (cnt_reg == WALK_LAST);
            exit_target = (next_dir_reg == DIR_EW) ? EW_G : NS_G;
         end
`ifdef NIGHT_FLASH_EN
         FLASH: begin
            phase_exit  = tick && !night;
            exit_target = AR_A;
         end
`endif
         default: begin
            // Unreachable code: recover to NS_G on the next edge regardless of tick.
            phase_exit  = 1'b1;
            exit_target = NS_G;
         end
      endcase
   end

   assign enter_walk = phase_exit && (exit_target == WALK);

   always_comb begin
      phase_next    = phase_reg;
      cnt_next      = cnt_reg;
      pend_next     = pend_reg;
      next_dir_next = next_dir_reg;
`ifdef NIGHT_FLASH_EN
      flash_next    = flash_reg;
`endif

      if (phase_exit) begin
         phase_next = exit_target;
         cnt_next   = '0;
      end else if (tick && (phase_reg != FLASH)) begin
         cnt_next = cnt_reg + 1'b1;
      end

      if (enter_walk) begin
         pend_next     = 1'b0;
         next_dir_next = (phase_reg == AR_A) ? DIR_EW : DIR_NS;
      end else if (ped_req && (phase_reg != WALK)) begin
         pend_next = 1'b1;
      end

`ifdef NIGHT_FLASH_EN
      if (phase_exit && (exit_target == FLASH)) begin
         flash_next = 1'b1;
      end else if ((phase_reg == FLASH) && tick) begin
         flash_next = ~flash_reg;
      end
`endif
   end

   always_comb begin
      ns_light  = LAMP_RED;
      ew_light  = LAMP_RED;
      ped_walk  = 1'b0;
      remaining = '0;
      case (phase_reg)
         NS_G: begin
            ns_light  = LAMP_GREEN;
            remaining = green_done ? '0 : (GREEN_LAST - cnt_reg);
         end
         NS_Y: begin
            ns_light  = LAMP_YELLOW;
            remaining = YELLOW_LAST - cnt_reg;
         end
         EW_G: begin
            ew_light  = LAMP_GREEN;
            remaining = green_done ? '0 : (GREEN_LAST - cnt_reg);
         end
         EW_Y: begin
            ew_light  = LAMP_YELLOW;
            remaining = YELLOW_LAST - cnt_reg;
         end
         AR_A, AR_B: begin
            remaining = ALLRED_LAST - cnt_reg;
         end
         WALK: begin
            ped_walk  = 1'b1;
            remaining = WALK_LAST - cnt_reg;
         end
`ifdef NIGHT_FLASH_EN
         FLASH: begin
            ns_light = {1'b0, flash_reg, 1'b0};
            ew_light = {1'b0, flash_reg, 1'b0};
         end
`endif
         default: begin
            ns_light = LAMP_RED;
         end
      endcase
   end

   assign ped_pending = pend_reg;
   assign phase       = phase_reg;

endmodule
